// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Handles unsigned and two's-complement operands with a start/busy/done
// handshake. Divide-by-zero and signed overflow are reported as flags
// that are held together with the result.
module div_seq #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  // The partial remainder is always below the divisor after an iteration,
  // so only DEN_W bits need to be stored; the extra bit lives in pr_shift.
  logic [DEN_W-1:0] pr_reg;
  logic [NUM_W-1:0] nq_reg;
  logic [DEN_W-1:0] den_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dz_reg;
  logic             ovf_reg;

  // Operand preparation signals (used at the capture edge)
  logic             num_neg;
  logic             den_neg;
  logic [NUM_W-1:0] num_mag;
  logic [DEN_W-1:0] den_mag;
  logic             den_zero;
  logic             ovf_cond;

  // One iteration step and result formation
  logic [DEN_W:0]   pr_shift;
  logic [DEN_W:0]   diff;
  logic [DEN_W-1:0] pr_next;
  logic [NUM_W-1:0] nq_next;
  logic [NUM_W-1:0] q_final;
  logic [DEN_W-1:0] r_final;
  logic             last_step;

  // Magnitudes, signs and special-case detection for the incoming operands
  always_comb begin
    num_neg  = signed_mode & numerator[NUM_W-1];
    den_neg  = signed_mode & denominator[DEN_W-1];
    num_mag  = num_neg ? -numerator : numerator;
    den_mag  = den_neg ? -denominator : denominator;
    den_zero = (denominator == '0);
    ovf_cond = signed_mode && (numerator == {1'b1, {(NUM_W-1){1'b0}}})
               && (denominator == '1);
  end

  // Shift-subtract step; the sign of the trial difference decides the bit
  always_comb begin
    pr_shift  = {pr_reg, nq_reg[NUM_W-1]};
    diff      = pr_shift - {1'b0, den_reg};
    pr_next   = pr_shift[DEN_W-1:0];
    nq_next   = {nq_reg[NUM_W-2:0], 1'b0};
    if (!diff[DEN_W]) begin
      pr_next = diff[DEN_W-1:0];
      nq_next = {nq_reg[NUM_W-2:0], 1'b1};
    end
    q_final   = sign_q_reg ? -nq_next : nq_next;
    r_final   = sign_r_reg ? -pr_next : pr_next;
    last_step = dz_reg || (cnt_reg == CNT_W'(1));
  end

  // Control FSM, iteration registers and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pr_reg      <= '0;
      nq_reg      <= '0;
      den_reg     <= '0;
      cnt_reg     <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      dz_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          pr_reg  <= pr_next;
          nq_reg  <= nq_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (last_step) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            if (dz_reg) begin
              // nq_reg still holds the raw numerator in this case
              quotient    <= '1;
              remainder   <= nq_reg[DEN_W-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (ovf_reg) begin
              quotient    <= {1'b1, {(NUM_W-1){1'b0}}};
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              quotient    <= q_final;
              remainder   <= r_final;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          done <= 1'b0;
          if (start) begin
            state_reg  <= RUN;
            busy       <= 1'b1;
            pr_reg     <= '0;
            nq_reg     <= den_zero ? numerator : num_mag;
            den_reg    <= den_mag;
            cnt_reg    <= CNT_W'(NUM_W);
            sign_q_reg <= num_neg ^ den_neg;
            sign_r_reg <= num_neg;
            dz_reg     <= den_zero;
            ovf_reg    <= ovf_cond;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
